rv_mem_arb: RTL and testbench

RV_MEM_ARB -- requirements
Module: rv_mem_arb

---
 rtl/rv_mem_arb.sv | 105 ++++++++++
 tb/tb_rv_mem_arb.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/rv_mem_arb.sv
// Round-robin arbiter merging an instruction-fetch port and a data port onto one memory bus.
// Minimum three cycles per access; a stalled memory is abandoned after TIMEOUT bus cycles with err.
module rv_mem_arb #(
  parameter int DPWIDTH = 32,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_req,
  input  logic [DPWIDTH-1:0] i_addr,
  output logic [DPWIDTH-1:0] i_rdata,
  output logic               i_ack,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [DPWIDTH-1:0] d_addr,
  input  logic [DPWIDTH-1:0] d_wdata,
  output logic [DPWIDTH-1:0] d_rdata,
  output logic               d_ack,
  output logic               err,
  output logic               m_req,
  output logic               m_we,
  output logic [DPWIDTH-1:0] m_addr,
  output logic [DPWIDTH-1:0] m_wdata,
  input  logic [DPWIDTH-1:0] m_rdata,
  input  logic               m_ack
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] IBUS = 2'd1;
  localparam logic [1:0] DBUS = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  localparam logic [7:0]         WAIT_LAST = 8'(TIMEOUT - 1);
  localparam logic [DPWIDTH-1:0] ERR_DATA  = DPWIDTH'(32'hDEADBEEF);

  logic [1:0] state;
  logic       last_data;  // 1: data port won the most recent grant
  logic       gnt_data;   // owner of the transaction in flight / being acked
  logic       err_q;
  logic [7:0] wait_cnt;

  assign m_req = (state == IBUS) || (state == DBUS);
  assign i_ack = (state == RESP) && !gnt_data;
  assign d_ack = (state == RESP) && gnt_data;
  assign err   = (state == RESP) && err_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      last_data <= 1'b1;
      gnt_data  <= 1'b0;
      err_q     <= 1'b0;
      wait_cnt  <= '0;
      m_we      <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Fetch wins when alone, or on a tie if data was served last.
          if (i_req && (!d_req || last_data)) begin
            state     <= IBUS;
            gnt_data  <= 1'b0;
            last_data <= 1'b0;
            m_addr    <= i_addr;
            m_we      <= 1'b0;
            m_wdata   <= '0;
            wait_cnt  <= '0;
          end else if (d_req) begin
            state     <= DBUS;
            gnt_data  <= 1'b1;
            last_data <= 1'b1;
            m_addr    <= d_addr;
            m_we      <= d_we;
            m_wdata   <= d_wdata;
            wait_cnt  <= '0;
          end
        end
        IBUS, DBUS: begin
          if (m_ack) begin
            state <= RESP;
            err_q <= 1'b0;
            if (state == IBUS) i_rdata <= m_rdata;
            else if (!m_we)    d_rdata <= m_rdata;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            if (wait_cnt == WAIT_LAST) begin
              state <= RESP;
              err_q <= 1'b1;
              if (state == IBUS) i_rdata <= ERR_DATA;
              else               d_rdata <= ERR_DATA;
            end
          end
        end
        default: begin
          state <= IDLE;
          err_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv_mem_arb.sv
// Bench for rv_mem_arb: directed table, randomized transactions against a transaction-level model, reset abort.
module tb_rv_mem_arb;
  localparam int T = 4;
  localparam logic [31:0] DEAD = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we, m_ack;
  logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic        i_ack, d_ack, err, m_req, m_we;

  rv_mem_arb #(.DPWIDTH(32), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .err(err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          ir;
    bit          dr;
    bit          we;
    logic [31:0] ia;
    logic [31:0] da;
    logic [31:0] wd;
    int          delay;      // bus cycles the memory waits before m_ack
    logic [31:0] mdata;      // memory returns mdata ^ m_addr
    int          exp_first;  // 0 fetch, 1 data
    bit          exp_err0;
  } vec_t;

  int total = 0;
  int bad = 0;
  int spurious = 0;

  // transaction-level model state
  bit          mdl_last_data;
  logic [31:0] mdl_i_rd, mdl_d_rd;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    mdl_last_data = 1'b1;
    mdl_i_rd = 32'h0;
    mdl_d_rd = 32'h0;
  endtask

  task automatic apply(input vec_t v, output int first_who, output bit first_err);
    int n_exp, n_got, bus, b;
    int ew[2]; logic [31:0] ed[2]; logic [31:0] ea[2]; bit ewe[2]; bit ee[2]; int el[2];
    int gw[2]; logic [31:0] gd[2]; logic [31:0] ga[2]; logic [31:0] gwd[2];
    bit gwe[2]; bit ge[2]; int gl[2]; bit gs[2];
    logic [31:0] s_addr, s_wd;
    bit s_we, stable;

    // Expected outcome from the arbitration rules.
    n_exp = 0;
    if (v.ir && v.dr) begin
      ew[0] = mdl_last_data ? 0 : 1;
      ew[1] = 1 - ew[0];
      n_exp = 2;
    end else if (v.ir) begin
      ew[0] = 0; n_exp = 1;
    end else if (v.dr) begin
      ew[0] = 1; n_exp = 1;
    end
    for (int k = 0; k < n_exp; k++) begin
      b      = (v.delay < T) ? v.delay + 1 : T;
      ee[k]  = (v.delay >= T);
      ea[k]  = (ew[k] == 1) ? v.da : v.ia;
      ewe[k] = (ew[k] == 1) && v.we;
      el[k]  = (k == 0) ? b + 1 : el[0] + 1 + b + 1;
      if (ee[k])       ed[k] = DEAD;
      else if (ewe[k]) ed[k] = mdl_d_rd;
      else             ed[k] = v.mdata ^ ea[k];
      if (ew[k] == 1) mdl_d_rd = ed[k];
      else            mdl_i_rd = ed[k];
      mdl_last_data = (ew[k] == 1);
    end

    @(negedge clk);
    i_req = v.ir; d_req = v.dr; d_we = v.we;
    i_addr = v.ia; d_addr = v.da; d_wdata = v.wd;
    n_got = 0; bus = 0; stable = 1'b1;
    s_addr = 32'h0; s_wd = 32'h0; s_we = 1'b0;
    for (int k = 0; k < 2; k++) begin
      gw[k] = -1; gd[k] = 32'h0; ga[k] = 32'h0; gwd[k] = 32'h0;
      gwe[k] = 1'b0; ge[k] = 1'b0; gl[k] = 0; gs[k] = 1'b0;
    end

    for (int cyc = 1; cyc <= 100 && n_got < n_exp; cyc++) begin
      @(negedge clk);
      if (m_req) begin
        bus++;
        if (bus == 1) begin
          s_addr = m_addr; s_we = m_we; s_wd = m_wdata; stable = 1'b1;
        end else if (m_addr !== s_addr || m_we !== s_we || m_wdata !== s_wd) begin
          stable = 1'b0;
        end
        m_ack   = (bus - 1 == v.delay);
        m_rdata = m_ack ? (v.mdata ^ m_addr) : $urandom();
      end else begin
        bus = 0;
        m_ack = 1'b0;
        m_rdata = $urandom();
      end
      if (err && !i_ack && !d_ack) spurious++;
      if (i_ack && d_ack) spurious++;
      if ((i_ack || d_ack) && n_got < 2) begin
        gw[n_got]  = d_ack ? 1 : 0;
        gd[n_got]  = d_ack ? d_rdata : i_rdata;
        ge[n_got]  = err;
        gl[n_got]  = cyc;
        ga[n_got]  = s_addr;
        gwe[n_got] = s_we;
        gwd[n_got] = s_wd;
        gs[n_got]  = stable;
        if (i_ack) i_req = 1'b0;
        if (d_ack) d_req = 1'b0;
        n_got++;
      end
    end
    m_ack = 1'b0; i_req = 1'b0; d_req = 1'b0;

    check("ack_count", n_got, n_exp);
    for (int k = 0; k < n_got; k++) begin
      check("grant_order", gw[k], ew[k]);
      check("rdata", gd[k], ed[k]);
      check("err", {31'h0, ge[k]}, {31'h0, ee[k]});
      check("latency", gl[k], el[k]);
      check("m_addr", ga[k], ea[k]);
      check("m_we", {31'h0, gwe[k]}, {31'h0, ewe[k]});
      check("m_stable", {31'h0, gs[k]}, 32'h1);
      if (ew[k] == 1) check("m_wdata", gwd[k], v.wd);
    end
    first_who = gw[0];
    first_err = ge[0];
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[13];
    vec_t rv;
    int   fw, r;
    bit   fe;

    // ir dr we   ia             da             wd             dly mdata          first err
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h40,       32'h0,        32'h0,        2,  32'h005000D3, 0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 32'h0,        32'h100,      32'hCAFE0001, 1,  32'h12345678, 1, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 32'h44,       32'h200,      32'h0,        0,  32'hA5A50000, 0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 32'h48,       32'h204,      32'h0,        1,  32'h0F0F0F0F, 0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 32'h4C,       32'h208,      32'h11112222, 2,  32'h33334444, 0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 32'h50,       32'h20C,      32'h0,        0,  32'h55556666, 0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'h54,       32'h0,        32'h0,        0,  32'h77778888, 0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 32'h58,       32'h210,      32'h0,        1,  32'h9999AAAA, 1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h300,      32'h0,        10, 32'hBBBBCCCC, 1, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h304,      32'h0,        0,  32'hDDDDEEEE, 1, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 32'h60,       32'h0,        32'h0,        3,  32'h13572468, 0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 32'h0,        32'h308,      32'hFEEDF00D, 7,  32'h24681357, 1, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 32'h64,       32'h0,        32'h0,        4,  32'h0BADC0DE, 0, 1'b1};

    rst = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; m_ack = 1'b0;
    i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; m_rdata = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_m_req", {31'h0, m_req}, 32'h0);
    check("rst_m_we", {31'h0, m_we}, 32'h0);
    check("rst_i_ack", {31'h0, i_ack}, 32'h0);
    check("rst_d_ack", {31'h0, d_ack}, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    check("rst_m_addr", m_addr, 32'h0);
    check("rst_m_wdata", m_wdata, 32'h0);
    check("rst_i_rdata", i_rdata, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);
    rst = 1'b1;
    model_reset();

    for (int i = 0; i < 13; i++) begin
      apply(tbl[i], fw, fe);
      check("tbl_first", fw, tbl[i].exp_first);
      check("tbl_err0", {31'h0, fe}, {31'h0, tbl[i].exp_err0});
    end

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(1, 3);
      rv.ir = (r & 1) != 0;
      rv.dr = (r & 2) != 0;
      rv.we = $urandom_range(0, 1) == 1;
      rv.ia = $urandom(); rv.da = $urandom(); rv.wd = $urandom();
      rv.delay = $urandom_range(0, 6);
      rv.mdata = $urandom();
      rv.exp_first = 0; rv.exp_err0 = 1'b0;
      apply(rv, fw, fe);
    end

    // Reset while a data access is stalled on the bus.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
    @(negedge clk);
    check("mid_dbus_m_req", {31'h0, m_req}, 32'h1);
    rst = 1'b0;
    @(negedge clk);
    check("abort_m_req", {31'h0, m_req}, 32'h0);
    check("abort_d_ack", {31'h0, d_ack}, 32'h0);
    check("abort_err", {31'h0, err}, 32'h0);
    check("abort_d_rdata", d_rdata, 32'h0);
    d_req = 1'b0;
    rst = 1'b1;
    model_reset();
    rv = '{1'b1, 1'b1, 1'b0, 32'h80, 32'h500, 32'h0, 1, 32'hC0FFEE00, 0, 1'b0};
    apply(rv, fw, fe);
    check("post_reset_tie_first", fw, 0);

    check("spurious_err_or_double_ack", spurious, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
